// File: rtl/tcam_search_engine.sv
// Pipelined TCAM search engine: NUM_BLOCKS row-addressed sub-blocks, a valid/ready
// request port for writes and searches, post-reset row clearing, and a 3-cycle search pipeline.
module tcam_search_engine #(
    parameter int NUM_BLOCKS = 4,
    parameter int SUB_ADDR_W = 7,
    parameter int DEPTH      = 64,
    parameter int WDATA_W    = 32,
    parameter int WMASK_W    = 4,
    localparam int KEY_W     = NUM_BLOCKS * SUB_ADDR_W,
    localparam int ROW_W     = SUB_ADDR_W + 1,
    localparam int BLK_W     = $clog2(NUM_BLOCKS),
    localparam int PMA_W     = $clog2(DEPTH)
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_req_valid,
    output logic                     out_req_ready,
    input  logic                     in_req_op,
    input  logic [KEY_W-1:0]         in_key,
    input  logic [BLK_W+ROW_W-1:0]   in_waddr,
    input  logic [WDATA_W-1:0]       in_wdata,
    input  logic [WMASK_W-1:0]       in_wmask,
    output logic                     out_rsp_valid,
    output logic                     out_match,
    output logic                     out_multi,
    output logic [PMA_W-1:0]         out_pma,
    output logic                     out_wr_err
);
    localparam int ROWS = 2 ** ROW_W;

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_WTURN = 2'd2} state_t;

    state_t                        state_r, next_state_s;
    logic [ROW_W-1:0]              init_cnt_r;
    logic                          ready_r;
    logic                          srch_acc_s, wr_acc_s;
    logic [BLK_W-1:0]              waddr_blk_s;
    logic [ROW_W-1:0]              waddr_row_s;
    logic [NUM_BLOCKS-1:0]         blk_sel_s;
    logic                          blk_ok_s;
    logic                          wr_en_s;
    logic [ROW_W-1:0]              wr_row_s;
    logic [WDATA_W-1:0]            wr_data_s;
    logic [NUM_BLOCKS*WMASK_W-1:0] wr_be_s;
    logic [WDATA_W-1:0]            mem_r [NUM_BLOCKS][ROWS];
    logic [DEPTH-1:0]              rd_r  [NUM_BLOCKS];
    logic [DEPTH-1:0]              rdq_r [NUM_BLOCKS];
    logic [DEPTH-1:0]              and_s, and_r;
    logic                          v0_r, v1_r, v2_r;
    logic [PMA_W-1:0]              pma_s;
    logic                          match_s, multi_s;

    // True when the vector has two or more bits set.
    function automatic logic multi_hot(input logic [DEPTH-1:0] v);
        return (v & (v - DEPTH'(1))) != '0;
    endfunction

    assign out_req_ready = ready_r;
    assign srch_acc_s    = in_req_valid && ready_r && !in_req_op;
    assign wr_acc_s      = in_req_valid && ready_r && in_req_op;
    assign waddr_blk_s   = in_waddr[ROW_W +: BLK_W];
    assign waddr_row_s   = in_waddr[ROW_W-1:0];

    // Decode the write block field; an out-of-range block selects nothing.
    always_comb begin
        blk_sel_s = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (waddr_blk_s == BLK_W'(b)) blk_sel_s[b] = 1'b1;
            else                          blk_sel_s[b] = 1'b0;
        end
        blk_ok_s = |blk_sel_s;
    end

    // FSM next state: INIT clears every row, a write costs one turnaround cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT:  next_state_s = (init_cnt_r == {ROW_W{1'b1}}) ? ST_IDLE : ST_INIT;
            ST_IDLE:  next_state_s = wr_acc_s ? ST_WTURN : ST_IDLE;
            ST_WTURN: next_state_s = ST_IDLE;
            default:  next_state_s = ST_INIT;
        endcase
    end

    // FSM state, init row counter and registered ready.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            ready_r    <= (next_state_s == ST_IDLE);
            if (state_r == ST_INIT) init_cnt_r <= init_cnt_r + ROW_W'(1);
            else                    init_cnt_r <= init_cnt_r;
        end
    end

    // Write port mux: INIT zeroes a row in all blocks, otherwise only the addressed block.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_row_s  = '0;
        wr_data_s = '0;
        wr_be_s   = '0;
        if (state_r == ST_INIT) begin
            wr_en_s  = 1'b1;
            wr_row_s = init_cnt_r;
            wr_be_s  = '1;
        end else if (wr_acc_s && blk_ok_s) begin
            wr_en_s   = 1'b1;
            wr_row_s  = waddr_row_s;
            wr_data_s = in_wdata;
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                wr_be_s[b*WMASK_W +: WMASK_W] = blk_sel_s[b] ? in_wmask : '0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Sub-block arrays: byte-masked write, both half-rows of the key slice read together.
    always_ff @(posedge in_clk) begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (wr_en_s) begin
                for (int by = 0; by < WMASK_W; by++) begin
                    if (wr_be_s[b*WMASK_W + by]) mem_r[b][wr_row_s][by*8 +: 8] <= wr_data_s[by*8 +: 8];
                end
            end
            if (srch_acc_s) begin
                rd_r[b] <= {mem_r[b][{in_key[b*SUB_ADDR_W +: SUB_ADDR_W], 1'b1}],
                            mem_r[b][{in_key[b*SUB_ADDR_W +: SUB_ADDR_W], 1'b0}]};
            end
        end
    end

    // AND-reduce across blocks and priority-encode the lowest matching entry.
    always_comb begin
        and_s = '1;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            and_s = and_s & rdq_r[b];
        end
        pma_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (and_r[i]) pma_s = PMA_W'(i);
            else          pma_s = pma_s;
        end
        match_s = |and_r;
        multi_s = multi_hot(and_r);
    end

    // Search pipeline and result registers; result fields hold between responses.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            v0_r          <= 1'b0;
            v1_r          <= 1'b0;
            v2_r          <= 1'b0;
            and_r         <= '0;
            for (int b = 0; b < NUM_BLOCKS; b++) rdq_r[b] <= '0;
            out_rsp_valid <= 1'b0;
            out_match     <= 1'b0;
            out_multi     <= 1'b0;
            out_pma       <= '0;
            out_wr_err    <= 1'b0;
        end else begin
            v0_r          <= srch_acc_s;
            v1_r          <= v0_r;
            v2_r          <= v1_r;
            for (int b = 0; b < NUM_BLOCKS; b++) rdq_r[b] <= rd_r[b];
            and_r         <= and_s;
            out_rsp_valid <= v2_r;
            out_wr_err    <= wr_acc_s && !blk_ok_s;
            if (v2_r) begin
                out_match <= match_s;
                out_multi <= multi_s;
                out_pma   <= pma_s;
            end else begin
                out_match <= out_match;
                out_multi <= out_multi;
                out_pma   <= out_pma;
            end
        end
    end
endmodule
